// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the RV32M/RV64M multiply/divide unit: funct3 op codes,
// FSM states and the operand-signedness helpers used at issue time.
package ex_muldiv_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    // MUL only keeps the low half, which is identical for signed and unsigned
    // operands, so it runs as unsigned.
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement of an N-bit value; purely combinational,
// no backpressure.
module muldiv_negate #(
    parameter int N = 32
) (
    input  logic [N-1:0] val,
    input  logic         neg,
    output logic [N-1:0] res
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    assign res = neg ? (~val + ONE) : val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: XLEN+1 cycles issue-to-result, 1 on the
// div-by-zero/overflow fast path; holds the pipeline via stall_req_o until DONE.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   reg1_i,
    input  logic [XLEN-1:0]   reg2_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic              flush_i,
    output logic [XLEN-1:0]   wdata_o,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              stall_req_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e state, state_nxt;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              sa_q;
    logic              sb_q;
    logic [REG_AW-1:0] wd_q;
    logic              wreg_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   res_q;

    // ---------------- issue-time decode ----------------
    logic            sgn_a_in, sgn_b_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;
    logic            accept;

    assign sgn_a_in = reg1_i[XLEN-1] & op_signed_a(op_i);
    assign sgn_b_in = reg2_i[XLEN-1] & op_signed_b(op_i);

    muldiv_negate #(.N(XLEN)) u_neg_a (.val(reg1_i), .neg(sgn_a_in), .res(a_mag));
    muldiv_negate #(.N(XLEN)) u_neg_b (.val(reg2_i), .neg(sgn_b_in), .res(b_mag));

    assign div_zero = op_i[2] && (reg2_i == '0);
    assign div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                      (reg1_i == MIN_NEG) && (reg2_i == '1);
    assign fast     = div_zero || div_ovf;

    // op_i[1] separates REM/REMU from DIV/DIVU.
    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = op_i[1] ? reg1_i : '1;
        end else if (div_ovf) begin
            fast_res = op_i[1] ? '0 : reg1_i;
        end
    end

    assign accept = (state == ST_IDLE) && start_i && !flush_i;

    // ---------------- one radix-2 step ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN:0]     div_hi;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_nxt;
    logic [2*XLEN-1:0] step_nxt;

    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

    // Shifted partial remainder needs one extra bit before the compare.
    assign div_hi   = acc_q[2*XLEN-1:XLEN-1];
    assign div_ge   = div_hi >= {1'b0, b_q};
    assign div_diff = div_hi[XLEN-1:0] - b_q;
    assign div_nxt  = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                             : {acc_q[2*XLEN-2:0], 1'b0};

    assign step_nxt = op_q[2] ? div_nxt : mul_nxt;

    // ---------------- sign fix-up on the final step ----------------
    logic [XLEN-1:0]   div_sel;
    logic [2*XLEN-1:0] fix_in;
    logic [2*XLEN-1:0] fix_out;
    logic              fix_neg;
    logic [XLEN-1:0]   fix_res;

    assign div_sel = op_q[1] ? step_nxt[2*XLEN-1:XLEN] : step_nxt[XLEN-1:0];
    assign fix_in  = op_q[2] ? {{XLEN{1'b0}}, div_sel} : step_nxt;
    assign fix_neg = (op_q[2] && op_q[1]) ? sa_q : (sa_q ^ sb_q);

    muldiv_negate #(.N(2*XLEN)) u_neg_res (.val(fix_in), .neg(fix_neg), .res(fix_out));

    assign fix_res = (op_q[2] || (op_q[1:0] == 2'b00)) ? fix_out[XLEN-1:0]
                                                      : fix_out[2*XLEN-1:XLEN];

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            wd_q   <= '0;
            wreg_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            res_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= op_i;
                a_q    <= a_mag;
                b_q    <= b_mag;
                sa_q   <= sgn_a_in;
                sb_q   <= sgn_b_in;
                wd_q   <= wd_i;
                wreg_q <= wreg_i;
                if (fast) begin
                    res_q <= fast_res;
                end else begin
                    cnt_q <= CNT_INIT;
                    acc_q <= op_i[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                end
            end else if ((state == ST_CALC) && !flush_i) begin
                acc_q <= step_nxt;
                cnt_q <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    res_q <= fix_res;
                end
            end
        end
    end

    // ---------------- next state and status outputs ----------------
    always_comb begin
        state_nxt   = state;
        done_o      = 1'b0;
        busy_o      = 1'b0;
        stall_req_o = 1'b0;
        wreg_o      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    stall_req_o = 1'b1;
                    state_nxt   = fast ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy_o      = 1'b1;
                stall_req_o = 1'b1;
                if (flush_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                wreg_o    = wreg_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wdata_o = res_q;
    assign wd_o    = wd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit at XLEN=32: arithmetic results, latency,
// stall shape, fast path, flush, mid-operation reset and issue interference.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic        done_o;
    logic        busy_o;
    logic        stall_req_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    ex_muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .done_o(done_o), .busy_o(busy_o), .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one op and waits (bounded) for done_o; lat = -1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd, input logic wr,
                          output int lat, output int stalls, output logic [31:0] res,
                          output logic [4:0] wdo, output logic wro, output logic stall_done);
        bit got;
        got = 0;
        @(negedge clk);
        op_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr; start_i = 1'b1;
        #1;
        stalls = stall_req_o ? 1 : 0;
        lat = 0; res = '0; wdo = '0; wro = 1'b0; stall_done = 1'b1;
        while (!got && lat < 100) begin
            @(negedge clk);
            start_i = 1'b0; reg1_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0;
            lat++;
            #1;
            if (done_o) begin
                got = 1; res = wdata_o; wdo = wd_o; wro = wreg_o; stall_done = stall_req_o;
            end else if (stall_req_o) begin
                stalls++;
            end
        end
        if (!got) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++; if (done_o !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else pass_cnt++;
        total_cnt++; if (stall_req_o !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_req_o); else pass_cnt++;
        total_cnt++; if (wreg_o !== 1'b0) $display("FAIL reset_wreg got=%b exp=0", wreg_o); else pass_cnt++;
        total_cnt++; if (wdata_o !== 32'h0) $display("FAIL reset_wdata got=%h exp=0", wdata_o); else pass_cnt++;
        total_cnt++; if (wd_o !== 5'h0) $display("FAIL reset_wd got=%h exp=0", wd_o); else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_mul();
        int lat, st;
        logic [31:0] res;
        logic [4:0] wdo;
        logic wro, sd;
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd9, 1'b1, lat, st, res, wdo, wro, sd);
        total_cnt++; if (res !== 32'hFFFFFFEB) $display("FAIL mul_res got=%h exp=ffffffeb", res); else pass_cnt++;
        total_cnt++; if (lat != 33) $display("FAIL mul_latency got=%0d exp=33", lat); else pass_cnt++;
        total_cnt++; if (st != 33) $display("FAIL mul_stall_cycles got=%0d exp=33", st); else pass_cnt++;
        total_cnt++; if (sd !== 1'b0) $display("FAIL mul_stall_in_done got=%b exp=0", sd); else pass_cnt++;
        total_cnt++; if (wro !== 1'b1) $display("FAIL mul_wreg got=%b exp=1", wro); else pass_cnt++;
        total_cnt++; if (wdo !== 5'd9) $display("FAIL mul_wd got=%0d exp=9", wdo); else pass_cnt++;
    endtask

    task automatic test_mulh();
        logic [2:0]  ops [3] = '{3'd1, 3'd3, 3'd2};
        logic [31:0] as  [3] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] bs  [3] = '{32'h80000000, 32'h80000000, 32'h00000002};
        logic [31:0] exp [3] = '{32'h40000000, 32'h40000000, 32'hFFFFFFFF};
        int lat, st;
        logic [31:0] res;
        logic [4:0] wdo;
        logic wro, sd;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], 5'd1, 1'b1, lat, st, res, wdo, wro, sd);
            total_cnt++;
            if (res !== exp[i]) $display("FAIL mulh_res[%0d] got=%h exp=%h", i, res, exp[i]); else pass_cnt++;
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        logic [4:0]  wds [4] = '{5'd5, 5'd17, 5'd30, 5'd12};
        logic        wrs [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int lat, st;
        logic [31:0] res;
        logic [4:0] wdo;
        logic wro, sd;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], wds[i], wrs[i], lat, st, res, wdo, wro, sd);
            total_cnt++; if (res !== exp[i]) $display("FAIL div_res[%0d] got=%h exp=%h", i, res, exp[i]); else pass_cnt++;
            total_cnt++; if (lat != 33) $display("FAIL div_latency[%0d] got=%0d exp=33", i, lat); else pass_cnt++;
            total_cnt++; if (wdo !== wds[i]) $display("FAIL div_wd[%0d] got=%0d exp=%0d", i, wdo, wds[i]); else pass_cnt++;
            total_cnt++; if (wro !== wrs[i]) $display("FAIL div_wreg[%0d] got=%b exp=%b", i, wro, wrs[i]); else pass_cnt++;
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [4] = '{32'd100, 32'd100, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd100, 32'h80000000, 32'h00000000};
        int lat, st;
        logic [31:0] res;
        logic [4:0] wdo;
        logic wro, sd;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'd2, 1'b1, lat, st, res, wdo, wro, sd);
            total_cnt++; if (res !== exp[i]) $display("FAIL fast_res[%0d] got=%h exp=%h", i, res, exp[i]); else pass_cnt++;
            total_cnt++; if (lat != 1) $display("FAIL fast_latency[%0d] got=%0d exp=1", i, lat); else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        int lat, st;
        logic [31:0] res;
        logic [4:0] wdo;
        logic wro, sd;
        @(negedge clk);
        op_i = 3'd4; reg1_i = 32'd1000; reg2_i = 32'd7; wd_i = 5'd4; wreg_i = 1'b1; start_i = 1'b1;
        repeat (9) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        total_cnt++; if (busy_o !== 1'b1) $display("FAIL flush_busy_before got=%b exp=1", busy_o); else pass_cnt++;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL flush_idle got=%b exp=0", busy_o); else pass_cnt++;
        total_cnt++; if (done_o !== 1'b0) $display("FAIL flush_done got=%b exp=0", done_o); else pass_cnt++;
        // A stray DIV completion would end this wait early with the wrong value.
        run_op(3'd0, 32'd3, 32'd5, 5'd11, 1'b1, lat, st, res, wdo, wro, sd);
        total_cnt++; if (res !== 32'd15) $display("FAIL flush_next_mul got=%h exp=0000000f", res); else pass_cnt++;
        total_cnt++; if (lat != 33) $display("FAIL flush_next_latency got=%0d exp=33", lat); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        @(negedge clk);
        op_i = 3'd0; reg1_i = 32'd6; reg2_i = 32'd6; wd_i = 5'd21; wreg_i = 1'b1; start_i = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy_o); else pass_cnt++;
        total_cnt++; if (stall_req_o !== 1'b0) $display("FAIL rstmid_stall got=%b exp=0", stall_req_o); else pass_cnt++;
        total_cnt++; if (done_o !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", done_o); else pass_cnt++;
        total_cnt++; if (wdata_o !== 32'h0) $display("FAIL rstmid_wdata got=%h exp=0", wdata_o); else pass_cnt++;
        total_cnt++; if (wd_o !== 5'h0) $display("FAIL rstmid_wd got=%h exp=0", wd_o); else pass_cnt++;
        rst = 1'b1;
        repeat (45) begin
            @(negedge clk);
            #1;
            if (done_o) dones++;
        end
        total_cnt++; if (dones != 0) $display("FAIL rstmid_no_done got=%0d exp=0", dones); else pass_cnt++;
    endtask

    task automatic test_interference();
        int lat;
        bit got;
        logic [31:0] res;
        logic [4:0] wdo;
        lat = 0; got = 0; res = '0; wdo = '0;
        @(negedge clk);
        op_i = 3'd5; reg1_i = 32'd100; reg2_i = 32'd7; wd_i = 5'd3; wreg_i = 1'b1; start_i = 1'b1;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                op_i = 3'd0; reg1_i = 32'd3; reg2_i = 32'd5; wd_i = 5'd8; start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            #1;
            if (done_o) begin
                got = 1; res = wdata_o; wdo = wd_o;
            end
        end
        start_i = 1'b0;
        total_cnt++; if (res !== 32'd14) $display("FAIL interf_res got=%h exp=0000000e", res); else pass_cnt++;
        total_cnt++; if (lat != 33) $display("FAIL interf_latency got=%0d exp=33", lat); else pass_cnt++;
        total_cnt++; if (wdo !== 5'd3) $display("FAIL interf_wd got=%0d exp=3", wdo); else pass_cnt++;
    endtask

    task automatic test_start_flush_idle();
        int dones;
        dones = 0;
        @(negedge clk);
        op_i = 3'd4; reg1_i = 32'd10; reg2_i = 32'd2; wd_i = 5'd7; start_i = 1'b1; flush_i = 1'b1;
        #1;
        total_cnt++; if (stall_req_o !== 1'b0) $display("FAIL idleflush_stall got=%b exp=0", stall_req_o); else pass_cnt++;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL idleflush_busy got=%b exp=0", busy_o); else pass_cnt++;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done_o) dones++;
        end
        total_cnt++; if (dones != 0) $display("FAIL idleflush_no_done got=%0d exp=0", dones); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_fast_path();
        test_flush();
        test_reset_mid();
        test_interference();
        test_start_flush_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle execute-stage unit for the RV32M/RV64M multiply/divide instructions.
- Sits beside the single-cycle EX ALU and is issued from ID/EX.
- Holds the pipeline through stall_req_o while it iterates, then returns one result with its destination register for the EX/MEM latch.
- Parametrised in data width. Handles the RISC-V divide-by-zero and signed-overflow cases in a single-cycle fast path.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- REG_AW, 5, destination register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start_i  in  1  issue strobe; accepted only in IDLE.
- op_i  in  3  operation, encoded as funct3: MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7.
- reg1_i  in  XLEN  rs1 operand (dividend / multiplicand).
- reg2_i  in  XLEN  rs2 operand (divisor / multiplier).
- wd_i  in  REG_AW  destination register.
- wreg_i  in  1  write enable for the destination register.
- flush_i  in  1  abort the in-flight operation (branch/exception).
- wdata_o  out  XLEN  result.
- wd_o  out  REG_AW  captured destination.
- wreg_o  out  1  write enable; high only in the DONE cycle.
- done_o  out  1  one-cycle result-valid pulse.
- busy_o  out  1  high in CALC and DONE.
- stall_req_o  out  1  pipeline stall request.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - All outputs and internal registers go to 0.
  - Applies mid-operation: the in-flight result is discarded and done_o is never asserted for it.
- FSM states: IDLE, CALC, DONE.
- IDLE, start_i=1, flush_i=0:
  - Capture op, operand magnitudes, operand signs, wd_i and wreg_i.
  - If op is DIV/DIVU/REM/REMU and reg2_i==0, or op is DIV/REM with reg1_i=-2^(XLEN-1) and reg2_i=-1, go to DONE (fast path).
  - Otherwise go to CALC and load the iteration counter with XLEN.
- CALC:
  - One radix-2 step per cycle.
  - Multiply: shift-add into a 2*XLEN-bit product register.
  - Divide: restoring step on a 2*XLEN-bit remainder/quotient register.
  - Counter decrements; when it reaches 1, go to DONE on the next edge.
  - Sign fix-up (two's-complement negate where required) is applied when entering DONE.
- DONE: wdata_o valid, done_o=1, wreg_o = captured wreg. Go to IDLE on the next edge.
- Latency, start edge to done_o: XLEN+1 cycles on the normal path, 1 cycle on the fast path.
- stall_req_o:
  - Combinational.
  - High when (IDLE and start_i and not flush_i), or in CALC.
  - Low in DONE, so the pipeline advances and latches the result that cycle.
- Result selection:
  - MUL: product[XLEN-1:0].
  - MULH / MULHSU / MULHU: product[2*XLEN-1:XLEN].
  - Signedness: MULH treats both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
  - Signed product is negated when the operand signs differ.
  - Quotient sign = sign(rs1) xor sign(rs2).
  - Remainder sign = sign(rs1).
- Fast-path results:
  - Division by 0: quotient = all ones, remainder = rs1.
  - Signed overflow: quotient = rs1, remainder = 0.
- Operands are captured at start; later changes on the inputs are ignored.
- start_i in CALC or DONE is ignored. No queuing; the issuer must respect stall_req_o.
- flush_i:
  - In CALC or DONE: go to IDLE next edge; done_o/wreg_o are suppressed from that edge.
  - In IDLE: flush_i with start_i in the same cycle means flush wins and nothing is accepted.
- rst has priority over flush_i, which has priority over start_i.

Decomposition:
- Shared package (Defines):
  - MULDIV op encodings (3-bit funct3 values).
  - FSM state encoding.
  - Default XLEN.
- One sub-module, muldiv_negate: conditional two's-complement of an N-bit value, parametrised N. Used for the operand magnitudes (XLEN) and the result fix-up (2*XLEN).

Test Plan (XLEN=32):
- MUL, reg1=7, reg2=0xFFFFFFFD (-3) -> done_o after 33 cycles, wdata_o=0xFFFFFFEB; stall_req_o high for 33 cycles, low in the done cycle.
- MULH, 0x80000000 x 0x80000000 -> wdata_o=0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2; each returned after 33 cycles with wd_o equal to the issued wd_i.
- Fast path:
  - DIVU 100/0 -> 0xFFFFFFFF after 1 cycle.
  - REM 100%0 -> 100 after 1 cycle.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 cycle.
  - REM 0x80000000%0xFFFFFFFF -> 0 after 1 cycle.
- Abort and reset:
  - Flush at cycle 10 of a DIV -> no done_o, IDLE next cycle.
  - A new MUL 3x5 issued immediately after -> 15.
  - rst=0 at cycle 5 -> all outputs 0, no done_o.
- Interference:
  - start_i pulsed during CALC with different operands -> ignored; the original result is returned.
  - start_i and flush_i together in IDLE -> nothing accepted.
